z80_branch_seq: RTL and testbench
=================================

Z80_BRANCH_SEQ -- requirements
Module: z80_branch_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of IP, SP and memory address.
REQ-002 SHALL have parameter RAS_DEPTH, default 8: shadow return-address stack entries; 0 removes the stack and ties ras_mismatch to 0.
REQ-003 SHALL use one clock with asynchronous, active-high reset.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- op  in  3  0 JP_CC, 1 JR_CC, 2 CALL, 3 CALL_CC, 4 RET, 5 RET_CC, 6 RST
- cond  in  3  condition code, or RST vector index
- nn  in  ADDR_W  absolute target; JR uses nn[7:0] as signed displacement
- f_in  in  8  flag register
- ip_in, sp_in  in  ADDR_W  register values at instruction start
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid with mem_ack
- mem_ack  in  1  bus cycle complete
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- taken  out  1  condition met, valid with done
- ip_out, sp_out  out  ADDR_W  results, valid with done
- ras_mismatch  out  1  one-cycle pulse with done on a failed RET check

Function
REQ-004 Condition decode SHALL select the flag: cond 0/1 Z (bit 6), 2/3 C (bit 0), 4/5 P/V (bit 2), 6/7 S (bit 7); met = (flag == cond[0]).
REQ-005 JP_CC, JR_CC, CALL_CC and RET_CC SHALL use REQ-004; CALL, RET and RST SHALL always be taken.
REQ-006 States SHALL be IDLE, EVAL, PUSH_HI, PUSH_LO, POP_LO, POP_HI, FIN.
REQ-007 IDLE + start SHALL latch all inputs and go to EVAL; start while busy SHALL be ignored.
REQ-008 EVAL SHALL take one cycle and go to PUSH_HI (taken CALL/RST), POP_LO (taken RET), else FIN.
REQ-009 Return address SHALL be ip_in+3 for CALL/CALL_CC and ip_in+1 for RST.
REQ-010 PUSH_HI SHALL write retaddr[15:8] to sp_in-1; PUSH_LO SHALL write retaddr[7:0] to sp_in-2; sp_out = sp_in-2.
REQ-011 POP_LO SHALL read address sp_in; POP_HI SHALL read sp_in+1; ip_out = {hi,lo}; sp_out = sp_in+2.
REQ-012 Each bus state SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack, then advance; wait cycles are unbounded.
REQ-013 Taken target SHALL be: JP nn; JR ip_in+2+sign-extended nn[7:0]; CALL nn; RST {cond,3'b000} zero-extended.
REQ-014 Not-taken ip_out SHALL be ip_in+3 (JP_CC, CALL_CC), ip_in+2 (JR_CC), ip_in+1 (RET_CC); sp_out = sp_in.
REQ-015 All address arithmetic SHALL be modulo 2^ADDR_W.
REQ-016 FIN SHALL assert done for one cycle and return to IDLE; start is acceptable the cycle after done.
REQ-017 The RAS SHALL be a circular buffer with a count saturating at RAS_DEPTH. A taken CALL/RST SHALL push retaddr at FIN. On a push when full, the oldest entry SHALL be overwritten.
REQ-018 A taken RET SHALL pop at FIN when count>0 and pulse ras_mismatch if the popped value differs from the read ip_out. A RET with count==0 SHALL NOT flag.
REQ-019 op values 7 SHALL complete as not-taken, ip_out = ip_in+1, no bus activity.

Reset
REQ-020 Reset SHALL force IDLE; clear the RAS pointer and count; drive mem_req, mem_we, done, taken, ras_mismatch and busy to 0; set ip_out, sp_out and mem_addr to 0; set mem_wdata to 0.
REQ-021 Reset mid-bus-cycle SHALL drop mem_req immediately; a late mem_ack SHALL be ignored.

Structure
REQ-022 The op encoding, flag bit numbers and state enum SHALL live in the shared z80 package.
REQ-023 The RAS SHALL be a sub-module z80_ras (push, pop, data, count), generated only when RAS_DEPTH>0.

Verification
REQ-024 CALL_CC cond=1, f_in=8'h40, ip=16'h1000, sp=16'h8000, nn=16'h2345, mem_ack with 2 waits -> writes 8'h10@7FFF and 8'h03@7FFE; ip_out=2345; sp_out=7FFE; taken=1.
REQ-025 Same request with f_in=0 -> no mem_req; ip_out=1003; sp_out=8000; taken=0; done 2 cycles after start.
REQ-026 CALL then RET reading back 8'h03 and 8'h10 -> ip_out=1003, sp_out=8000, ras_mismatch=0; a second RET reading 8'h00 and 8'h50 -> ras_mismatch=0 (stack empty).
REQ-027 JR_CC cond=3, C=1, ip=16'h0010, nn[7:0]=8'hFC -> ip_out=000E; sp=16'h0000 with a taken CALL -> writes to FFFF/FFFE and sp_out=FFFE.
REQ-028 Nine CALLs with RAS_DEPTH=8, then a RET returning the first CALL's address -> ras_mismatch=1 (oldest entry overwritten).
REQ-029 Reset asserted during PUSH_LO wait -> mem_req=0 at once; after release, busy=0 and the next start is accepted.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared Z80 definitions: branch op encoding, flag bit positions and
// branch-sequencer state encoding.
package z80_pkg;

  typedef enum logic [2:0] {
    OP_JP_CC   = 3'd0,
    OP_JR_CC   = 3'd1,
    OP_CALL    = 3'd2,
    OP_CALL_CC = 3'd3,
    OP_RET     = 3'd4,
    OP_RET_CC  = 3'd5,
    OP_RST     = 3'd6,
    OP_NONE    = 3'd7
  } op_e;

  localparam logic [2:0] FLAG_Z  = 3'd6;
  localparam logic [2:0] FLAG_C  = 3'd0;
  localparam logic [2:0] FLAG_PV = 3'd2;
  localparam logic [2:0] FLAG_S  = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    PUSH_HI = 3'd2,
    PUSH_LO = 3'd3,
    POP_LO  = 3'd4,
    POP_HI  = 3'd5,
    FIN     = 3'd6
  } state_e;

  // cond[2:1] picks the flag, cond[0] is the required flag value
  function automatic logic [2:0] flag_index(input logic [1:0] sel);
    case (sel)
      2'd0:    return FLAG_Z;
      2'd1:    return FLAG_C;
      2'd2:    return FLAG_PV;
      default: return FLAG_S;
    endcase
  endfunction

endpackage

// File: rtl/z80_ras.sv
// Shadow return-address stack: circular buffer whose oldest entry is
// overwritten on a push when full; count saturates at DEPTH.
module z80_ras #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     entries [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  // ptr is the next write slot; the top of stack sits just below it
  always_comb begin
    ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
    ptr_dec = (ptr == '0) ? LAST : ptr - 1'b1;
  end

  assign data = entries[ptr_dec];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[ptr] <= push_data;
  end

endmodule

// File: rtl/z80_branch_seq.sv
// Z80 conditional jump/call/return/restart sequencer with stack bus cycles
// and an optional shadow return-address stack for return checking.
module z80_branch_seq
  import z80_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [2:0]        cond,
  input  logic [ADDR_W-1:0] nn,
  input  logic [7:0]        f_in,
  input  logic [ADDR_W-1:0] ip_in,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic [ADDR_W-1:0] ip_out,
  output logic [ADDR_W-1:0] sp_out,
  output logic              ras_mismatch
);

  localparam int CNT_W = (RAS_DEPTH > 0) ? $clog2(RAS_DEPTH + 1) : 1;

  state_e            state, state_nxt;
  op_e               op_r;
  logic [2:0]        cond_r;
  logic [ADDR_W-1:0] nn_r, ip_r, sp_r;
  logic [7:0]        f_r, lo_r;
  logic              taken_r;
  logic [ADDR_W-1:0] ip_res, sp_res;

  logic              met, cond_ok, is_push, is_pop;
  logic [ADDR_W-1:0] ret_addr, target_ip, fall_ip, taken_sp, jr_disp;

  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;

  always_comb begin
    met      = (f_r[flag_index(cond_r[2:1])] == cond_r[0]);
    jr_disp  = {{(ADDR_W-8){nn_r[7]}}, nn_r[7:0]};
    ret_addr = (op_r == OP_RST) ? ip_r + ADDR_W'(1) : ip_r + ADDR_W'(3);
    cond_ok  = 1'b0;
    is_push  = 1'b0;
    is_pop   = 1'b0;
    fall_ip  = ip_r + ADDR_W'(1);
    target_ip = ip_r + ADDR_W'(1);
    case (op_r)
      OP_JP_CC:   begin cond_ok = met;  target_ip = nn_r; fall_ip = ip_r + ADDR_W'(3); end
      OP_JR_CC:   begin cond_ok = met;  target_ip = ip_r + ADDR_W'(2) + jr_disp;
                        fall_ip = ip_r + ADDR_W'(2); end
      OP_CALL:    begin cond_ok = 1'b1; is_push = 1'b1; target_ip = nn_r; end
      OP_CALL_CC: begin cond_ok = met;  is_push = 1'b1; target_ip = nn_r;
                        fall_ip = ip_r + ADDR_W'(3); end
      OP_RET:     begin cond_ok = 1'b1; is_pop = 1'b1; end
      OP_RET_CC:  begin cond_ok = met;  is_pop = 1'b1; end
      OP_RST:     begin cond_ok = 1'b1; is_push = 1'b1; target_ip = ADDR_W'({cond_r, 3'b000}); end
      default:    ;
    endcase
    taken_sp = is_push ? sp_r - ADDR_W'(2) : (is_pop ? sp_r + ADDR_W'(2) : sp_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus signals come straight from the state so reset drops mem_req at once
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state)
      IDLE:    if (start) state_nxt = EVAL;
      EVAL:    state_nxt = (cond_ok && is_push) ? PUSH_HI :
                           (cond_ok && is_pop)  ? POP_LO  : FIN;
      PUSH_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_r - ADDR_W'(1);
        mem_wdata = 8'(ret_addr >> 8);
        if (mem_ack) state_nxt = PUSH_LO;
      end
      PUSH_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_r - ADDR_W'(2);
        mem_wdata = ret_addr[7:0];
        if (mem_ack) state_nxt = FIN;
      end
      POP_LO: begin
        mem_req  = 1'b1;
        mem_addr = sp_r;
        if (mem_ack) state_nxt = POP_HI;
      end
      POP_HI: begin
        mem_req  = 1'b1;
        mem_addr = sp_r + ADDR_W'(1);
        if (mem_ack) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r    <= OP_NONE;
      cond_r  <= '0;
      nn_r    <= '0;
      f_r     <= '0;
      ip_r    <= '0;
      sp_r    <= '0;
      lo_r    <= '0;
      taken_r <= 1'b0;
      ip_res  <= '0;
      sp_res  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r   <= op_e'(op);
          cond_r <= cond;
          nn_r   <= nn;
          f_r    <= f_in;
          ip_r   <= ip_in;
          sp_r   <= sp_in;
        end
        EVAL: begin
          taken_r <= cond_ok;
          ip_res  <= cond_ok ? target_ip : fall_ip;
          sp_res  <= cond_ok ? taken_sp : sp_r;
        end
        POP_LO: if (mem_ack) lo_r <= mem_rdata;
        POP_HI: if (mem_ack) ip_res <= ADDR_W'({mem_rdata, lo_r});
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == FIN);
  assign taken  = taken_r;
  assign ip_out = ip_res;
  assign sp_out = sp_res;

  assign ras_push     = done && taken_r && is_push;
  assign ras_pop      = done && taken_r && is_pop && (ras_count != '0);
  assign ras_mismatch = ras_pop && (ras_top != ip_res);

  if (RAS_DEPTH > 0) begin : g_ras
    z80_ras #(
      .DEPTH(RAS_DEPTH),
      .W    (ADDR_W)
    ) u_ras (
      .clk      (clk),
      .reset    (reset),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_data(ret_addr),
      .data     (ras_top),
      .count    (ras_count)
    );
  end else begin : g_no_ras
    assign ras_top   = '0;
    assign ras_count = '0;
  end

endmodule

// File: tb/tb_z80_branch_seq.sv
// Directed bench for z80_branch_seq: a byte-wide bus responder with
// programmable wait states and hand-computed expected results.
module tb_z80_branch_seq;
  import z80_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0, cond = '0;
  logic [15:0] nn = '0, ip_in = '0, sp_in = '0;
  logic [7:0]  f_in = '0;
  logic        mem_req, mem_we, mem_ack, busy, done, taken, ras_mismatch;
  logic [15:0] mem_addr, ip_out, sp_out;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  rd_mem [0:65535];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] res_ip, res_sp;
  logic        res_taken, res_mis;
  int          res_lat, res_req, wr_base;

  assign mem_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  z80_branch_seq #(.ADDR_W(16), .RAS_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cond(cond), .nn(nn),
    .f_in(f_in), .ip_in(ip_in), .sp_in(sp_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .taken(taken),
    .ip_out(ip_out), .sp_out(sp_out), .ras_mismatch(ras_mismatch)
  );

  // Bus responder: acks after wait_cycles idle cycles, logs writes
  always @(negedge clk) begin
    if (reset) begin
      resp_ack = 1'b0;
      wcnt = 0;
    end else if (resp_ack) begin
      resp_ack = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      req_cycles++;
      if (wcnt >= wait_cycles) begin
        resp_ack = 1'b1;
        if (mem_we) begin
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          mem_rdata = rd_mem[mem_addr];
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [2:0] c, input logic [15:0] n,
                               input logic [7:0] f, input logic [15:0] ip, input logic [15:0] sp,
                               input int waits);
    int req0;
    wait_cycles = waits;
    wr_base = wr_addr_q.size();
    req0 = req_cycles;
    op = o; cond = c; nn = n; f_in = f; ip_in = ip; sp_in = sp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res_lat = 1;
    while (done !== 1'b1 && res_lat < 300) begin
      @(negedge clk);
      res_lat++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", 32'(done), 32'd1);
    res_ip = ip_out;
    res_sp = sp_out;
    res_taken = taken;
    res_mis = ras_mismatch;
    res_req = req_cycles - req0;
    @(negedge clk);
  endtask

  task automatic checkWrites(input string tag, input logic [15:0] a0, input logic [7:0] d0,
                             input logic [15:0] a1, input logic [7:0] d1);
    checkOutput({tag, "_wr_count"}, 32'(wr_addr_q.size() - wr_base), 32'd2);
    if (wr_addr_q.size() >= wr_base + 2) begin
      checkOutput({tag, "_wr0_addr"}, 32'(wr_addr_q[wr_base]), 32'(a0));
      checkOutput({tag, "_wr0_data"}, 32'(wr_data_q[wr_base]), 32'(d0));
      checkOutput({tag, "_wr1_addr"}, 32'(wr_addr_q[wr_base+1]), 32'(a1));
      checkOutput({tag, "_wr1_data"}, 32'(wr_data_q[wr_base+1]), 32'(d1));
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_ip_out", 32'(ip_out), 32'h0);
    checkOutput("rst_sp_out", 32'(sp_out), 32'h0);
    checkOutput("rst_ras_mis", 32'(ras_mismatch), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Taken CALL_CC (Z set) with two wait states per bus cycle
    applyStimulus(3'(OP_CALL_CC), 3'd1, 16'h2345, 8'h40, 16'h1000, 16'h8000, 2);
    checkWrites("callcc", 16'h7FFF, 8'h10, 16'h7FFE, 8'h03);
    checkOutput("callcc_ip", 32'(res_ip), 32'h2345);
    checkOutput("callcc_sp", 32'(res_sp), 32'h7FFE);
    checkOutput("callcc_taken", 32'(res_taken), 32'd1);

    // Same request not taken: no bus traffic, two-cycle latency
    applyStimulus(3'(OP_CALL_CC), 3'd1, 16'h2345, 8'h00, 16'h1000, 16'h8000, 2);
    checkOutput("callcc_nt_req", 32'(res_req), 32'd0);
    checkOutput("callcc_nt_ip", 32'(res_ip), 32'h1003);
    checkOutput("callcc_nt_sp", 32'(res_sp), 32'h8000);
    checkOutput("callcc_nt_taken", 32'(res_taken), 32'd0);
    checkOutput("callcc_nt_lat", 32'(res_lat), 32'd2);

    // RET matching the earlier CALL, then a RET with the shadow stack empty
    rd_mem[16'h7FFE] = 8'h03; rd_mem[16'h7FFF] = 8'h10;
    applyStimulus(3'(OP_RET), 3'd0, 16'h0000, 8'h00, 16'h2345, 16'h7FFE, 1);
    checkOutput("ret_ip", 32'(res_ip), 32'h1003);
    checkOutput("ret_sp", 32'(res_sp), 32'h8000);
    checkOutput("ret_mis", 32'(res_mis), 32'd0);
    rd_mem[16'h8000] = 8'h00; rd_mem[16'h8001] = 8'h50;
    applyStimulus(3'(OP_RET), 3'd0, 16'h0000, 8'h00, 16'h1003, 16'h8000, 0);
    checkOutput("ret2_ip", 32'(res_ip), 32'h5000);
    checkOutput("ret2_sp", 32'(res_sp), 32'h8002);
    checkOutput("ret2_mis", 32'(res_mis), 32'd0);

    // JR with negative displacement, taken and not taken
    applyStimulus(3'(OP_JR_CC), 3'd3, 16'h00FC, 8'h01, 16'h0010, 16'h1234, 0);
    checkOutput("jr_ip", 32'(res_ip), 32'h000E);
    checkOutput("jr_sp", 32'(res_sp), 32'h1234);
    checkOutput("jr_taken", 32'(res_taken), 32'd1);
    applyStimulus(3'(OP_JR_CC), 3'd3, 16'h00FC, 8'h00, 16'h0010, 16'h1234, 0);
    checkOutput("jr_nt_ip", 32'(res_ip), 32'h0012);

    // CALL with SP wrapping below zero
    applyStimulus(3'(OP_CALL), 3'd0, 16'h1234, 8'h00, 16'h0100, 16'h0000, 0);
    checkWrites("call_wrap", 16'hFFFF, 8'h01, 16'hFFFE, 8'h03);
    checkOutput("call_wrap_sp", 32'(res_sp), 32'hFFFE);
    checkOutput("call_wrap_ip", 32'(res_ip), 32'h1234);

    // RST 28h pushes ip+1
    applyStimulus(3'(OP_RST), 3'd5, 16'h0000, 8'h00, 16'h0200, 16'h9000, 1);
    checkWrites("rst", 16'h8FFF, 8'h02, 16'h8FFE, 8'h01);
    checkOutput("rst_ip", 32'(res_ip), 32'h0028);
    checkOutput("rst_sp", 32'(res_sp), 32'h8FFE);

    // RET_CC on Z clear with Z set: falls through
    applyStimulus(3'(OP_RET_CC), 3'd0, 16'h0000, 8'h40, 16'h3000, 16'h7000, 0);
    checkOutput("retcc_nt_ip", 32'(res_ip), 32'h3001);
    checkOutput("retcc_nt_sp", 32'(res_sp), 32'h7000);
    checkOutput("retcc_nt_req", 32'(res_req), 32'd0);
    checkOutput("retcc_nt_taken", 32'(res_taken), 32'd0);

    // JP_CC on sign flag, both polarities
    applyStimulus(3'(OP_JP_CC), 3'd7, 16'hABCD, 8'h80, 16'h0500, 16'h7000, 0);
    checkOutput("jp_s_ip", 32'(res_ip), 32'hABCD);
    applyStimulus(3'(OP_JP_CC), 3'd6, 16'hABCD, 8'h80, 16'h0500, 16'h7000, 0);
    checkOutput("jp_ns_ip", 32'(res_ip), 32'h0503);
    checkOutput("jp_ns_taken", 32'(res_taken), 32'd0);

    // Reserved op 7 completes as a not-taken one-byte instruction
    applyStimulus(3'd7, 3'd0, 16'hFFFF, 8'hFF, 16'hFFFF, 16'h4444, 0);
    checkOutput("op7_ip", 32'(res_ip), 32'h0000);
    checkOutput("op7_taken", 32'(res_taken), 32'd0);
    checkOutput("op7_req", 32'(res_req), 32'd0);

    // Nine CALLs overflow the 8-entry shadow stack
    for (int i = 0; i < 9; i++) begin
      applyStimulus(3'(OP_CALL), 3'd0, 16'h6000, 8'h00, 16'h4000 + 16'(i * 16), 16'hC000, 0);
    end
    checkOutput("call9_ip", 32'(res_ip), 32'h6000);
    rd_mem[16'hD000] = 8'h03; rd_mem[16'hD001] = 8'h40;
    applyStimulus(3'(OP_RET), 3'd0, 16'h0000, 8'h00, 16'h6000, 16'hD000, 0);
    checkOutput("ras_ovf_ip", 32'(res_ip), 32'h4003);
    checkOutput("ras_ovf_mis", 32'(res_mis), 32'd1);
    rd_mem[16'hD002] = 8'h73; rd_mem[16'hD003] = 8'h40;
    applyStimulus(3'(OP_RET), 3'd0, 16'h0000, 8'h00, 16'h6000, 16'hD002, 0);
    checkOutput("ras_next_mis", 32'(res_mis), 32'd0);

    // Reset while PUSH_LO waits on the bus
    wait_cycles = 20;
    op = 3'(OP_CALL); cond = 3'd0; nn = 16'h2222; f_in = 8'h00; ip_in = 16'h1111; sp_in = 16'h8000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(mem_req === 1'b1 && mem_addr === 16'h7FFE) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("pushlo_reached", 32'(mem_addr), 32'h7FFE);
    reset = 1'b1;
    #1;
    checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles = 0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    checkOutput("late_ack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    applyStimulus(3'(OP_JP_CC), 3'd7, 16'h1357, 8'h80, 16'h0000, 16'h0000, 0);
    checkOutput("post_rst_ip", 32'(res_ip), 32'h1357);
    checkOutput("post_rst_lat", 32'(res_lat), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
